// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the 24-bit register bank.
// Optional macro REGARB_LOCK_EN adds req_lock so one requester can own the port across beats.
module regfile_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*DATA_W-1:0]  req_data,
`ifdef REGARB_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
`endif
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wr_stall,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [$clog2(NREQ)-1:0] wr_src
);
  localparam int SRC_W = $clog2(NREQ);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   eligible;
  logic              gnt_found;
  logic [SRC_W-1:0]  gnt_idx;
  logic              xfer;
  int unsigned       idx;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [SRC_W-1:0]  wr_src_q;

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

`ifdef REGARB_LOCK_EN
  logic             lock_active_q, lock_active_d;
  logic [SRC_W-1:0] lock_owner_q, lock_owner_d;

  always_comb begin
    eligible = req_valid;
    if (lock_active_q) eligible = req_valid & (NREQ'(1) << lock_owner_q);
  end
`else
  always_comb eligible = req_valid;
`endif

  // First eligible requester searching from rr_ptr upward, modulo NREQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!gnt_found && eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(idx);
      end
    end
    xfer      = gnt_found & ~wr_stall & ~rst;
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef REGARB_LOCK_EN
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
`endif
    if (xfer) begin
`ifdef REGARB_LOCK_EN
      if (req_lock[gnt_idx]) begin
        lock_active_d = 1'b1;
        lock_owner_d  = gnt_idx;
      end else begin
        lock_active_d = 1'b0;
        rr_ptr_d      = next_idx(gnt_idx);
      end
`else
      rr_ptr_d = next_idx(gnt_idx);
`endif
    end
`ifdef REGARB_LOCK_EN
    // Owner walked away: release the port as if it had completed its last beat
    else if (lock_active_q && !req_valid[lock_owner_q]) begin
      lock_active_d = 1'b0;
      rr_ptr_d      = next_idx(lock_owner_q);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= xfer;
      if (xfer) begin
        wr_addr_q <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        wr_data_q <= req_data[gnt_idx*DATA_W +: DATA_W];
        wr_src_q  <= gnt_idx;
      end
    end
  end

`ifdef REGARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_active_q <= 1'b0;
      lock_owner_q  <= '0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
    end
  end
`endif

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: queue-based reference model plus randomized traffic.
module tb_regfile_write_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int SRC_W  = 2;
`ifdef REGARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid, req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   wr_stall, wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [SRC_W-1:0]       wr_src;
`ifdef REGARB_LOCK_EN
  logic [NREQ-1:0]        req_lock;
`endif

  regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
`ifdef REGARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_src(wr_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [SRC_W-1:0]  s;
  } wr_t;

  int checks = 0;
  int passed = 0;
  wr_t exp_q[$];

  // Reference model: next requester to consider, lock ownership, held requests
  int ptr = 0;
  bit lock_on = 1'b0;
  int owner = 0;
  logic [ADDR_W-1:0] addr_a [NREQ];
  logic [DATA_W-1:0] data_a [NREQ];
  logic [NREQ-1:0]   held = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus, applied on the falling edge, with model prediction of the grant
  task automatic step(input logic [NREQ-1:0] v, input logic stall, input logic [NREQ-1:0] lk,
                      input logic r, output int g);
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && !held[i]) begin
        addr_a[i] = ADDR_W'($urandom);
        data_a[i] = DATA_W'($urandom);
      end
      req_addr[i*ADDR_W +: ADDR_W] = addr_a[i];
      req_data[i*DATA_W +: DATA_W] = data_a[i];
    end
    held      = v;
    rst       = r;
    req_valid = v;
    wr_stall  = stall;
`ifdef REGARB_LOCK_EN
    req_lock  = lk;
`endif
    #1;
    g = -1;
    if (!r && !stall) begin
      if (lock_on) begin
        if (v[owner]) g = owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      end
    end
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    if (r) begin
      ptr = 0;
      lock_on = 1'b0;
      exp_q.delete();
      chk("rst_wr_en", wr_en, 0);
    end else if (g >= 0) begin
      exp_q.push_back('{a: addr_a[g], d: data_a[g], s: SRC_W'(g)});
      held[g] = 1'b0;
      if (LOCK && lk[g]) begin
        lock_on = 1'b1;
        owner = g;
      end else begin
        lock_on = 1'b0;
        ptr = (g + 1) % NREQ;
      end
    end else if (lock_on && !v[owner]) begin
      lock_on = 1'b0;
      ptr = (owner + 1) % NREQ;
    end
  endtask

  // Monitor: every registered write must match the oldest predicted transfer, one cycle later
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        if (exp_q.size() == 0) chk("spurious_write", wr_en, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
          chk("wr_src", wr_src, e.s);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_write", wr_en, 1);
        exp_q.delete();
      end
    end
  end

  initial begin
    int g;
    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
    logic [NREQ-1:0] v, lk;
    logic st, r;

    rst = 1'b1; req_valid = '1; wr_stall = 1'b0; req_addr = '0; req_data = '0;
`ifdef REGARB_LOCK_EN
    req_lock = '0;
`endif
    #2;
    chk("reset_ready", req_ready, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_wr_src", wr_src, 0);

    step(4'b1111, 0, 0, 0, g);
    chk("first_grant", req_ready, 4'b0001);

    // Round robin with wrap
    step(4'b0000, 0, 0, 1, g);
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 0, 0, 0, g);
      chk("rr_seq", req_ready, NREQ'(1) << rr_seq[k]);
    end

    // Single requester with fixed payload
    step(4'b0000, 0, 0, 1, g);
    held[2] = 1'b1; addr_a[2] = 4'd5; data_a[2] = 24'hABCDEF;
    step(4'b0100, 0, 0, 0, g);
    chk("single_ready", req_ready, 4'b0100);
    step(4'b0000, 0, 0, 0, g);
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_addr", wr_addr, 5);
    chk("single_wr_data", wr_data, 24'hABCDEF);
    chk("single_wr_src", wr_src, 2);

    // Stall after grant to requester 1
    step(4'b0000, 0, 0, 1, g);
    step(4'b1111, 0, 0, 0, g);
    step(4'b1111, 0, 0, 0, g);
    for (int k = 0; k < 3; k++) step(4'b1111, 1, 0, 0, g);
    step(4'b1111, 0, 0, 0, g);
    chk("stall_resume", req_ready, 4'b0100);

    // Withdrawal, then reset the cycle after a grant
    step(4'b0000, 0, 0, 1, g);
    step(4'b1000, 1, 0, 0, g);
    step(4'b0000, 0, 0, 0, g);
    step(4'b0000, 0, 0, 0, g);
    step(4'b0010, 0, 0, 0, g);
    step(4'b0000, 0, 0, 1, g);
    step(4'b1111, 0, 0, 0, g);
    chk("post_reset_grant", req_ready, 4'b0001);

`ifdef REGARB_LOCK_EN
    step(4'b0000, 0, 0, 1, g);
    step(4'b1111, 0, 4'b0000, 0, g);
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 0, 4'b0010, 0, g);
      chk("lock_hold", req_ready, 4'b0010);
    end
    step(4'b1111, 0, 4'b0000, 0, g);
    chk("lock_last", req_ready, 4'b0010);
    step(4'b1111, 0, 4'b0000, 0, g);
    chk("lock_release", req_ready, 4'b0100);
`endif

    // Randomized traffic obeying the hold-until-ready rule, with occasional withdrawal
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++)
        v[i] = held[i] ? ($urandom_range(7) != 0) : ($urandom_range(1) == 1);
      st = ($urandom_range(4) == 0);
      r  = ($urandom_range(99) == 0);
      lk = NREQ'($urandom) & NREQ'($urandom);
      step(v, st, lk, r, g);
    end
    step(4'b0000, 0, 0, 0, g);
    step(4'b0000, 0, 0, 0, g);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 24-bit register bank between NREQ requesters (e.g. ALU writeback, load unit, vector unit, host/debug loader).
- Accepts one write per cycle over a valid/ready handshake.
- Drives registered write-enable, address and data to the bank's WriteEn/RegIn decode logic one cycle after grant.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- DATA_W, 24, data width written to the register bank.
- ADDR_W, 4, register index width (16 registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot grant; transfer for requester i when req_valid[i] & req_ready[i].
- wr_stall  in  1  bank busy; blocks all grants while high.
- wr_en  out  1  registered write enable to the bank.
- wr_addr  out  ADDR_W  registered write address.
- wr_data  out  DATA_W  registered write data.
- wr_src  out  $clog2(NREQ)  index of the requester that produced the current write.

Behaviour:
- Reset (async, immediate): rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, wr_src=0. req_ready is combinational and is 0 while rst is high.
- Grant (combinational):
  - If wr_stall=1 or no req_valid is set, then req_ready=0.
  - Otherwise the grant goes to the first valid requester found searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready never has more than one bit set.
  - req_ready[i] is never set while req_valid[i]=0.
- Pointer: on a transfer from requester g, rr_ptr <= (g+1) mod NREQ. The wrap from NREQ-1 goes to 0. With no transfer, rr_ptr holds.
- Output register:
  - On a transfer from g: wr_en<=1, wr_addr<=req_addr[g], wr_data<=req_data[g], wr_src<=g.
  - With no transfer: wr_en<=0, and wr_addr/wr_data/wr_src hold their previous values.
- Latency: exactly 1 cycle from handshake to wr_en. Sustained throughput: 1 write/cycle.
- Handshake rules:
  - A requester holds valid, addr and data stable until it sees ready.
  - It may drop valid before ready; the request is then withdrawn with no write.
  - Ready is not a promise across cycles.
- Fairness: with all NREQ valid continuously, grants rotate 0,1,...,NREQ-1,0. Each requester waits at most NREQ-1 cycles once valid.
- wr_stall rising mid-stream: the write already registered still appears on wr_en the next cycle; no new grant is issued while stall is high. rr_ptr is unaffected by stall.
- Reset mid-operation: a pending registered write is discarded (wr_en forced to 0). Arbitration restarts from requester 0.
- The block does not detect same-address hazards; ordering between requesters is grant order.

Optional Feature:
- Macro: REGARB_LOCK_EN.
- When defined:
  - Adds input req_lock (NREQ bits).
  - A transfer from g with req_lock[g]=1 sets lock_active and lock_owner=g; rr_ptr is not advanced.
  - While lock_active: only lock_owner can be granted (still subject to wr_stall); other requesters see ready=0.
  - Lock clears when the owner transfers with req_lock[g]=0, after which rr_ptr advances to g+1 as normal.
  - Lock also clears when the owner drops req_valid (rr_ptr set to owner+1), or on rst.
- When undefined: no req_lock port, no lock state; pure round-robin as above.

Test Plan:
- Reset: assert rst with req_valid=4'b1111 -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0. After release, the first grant goes to requester 0.
- Single requester: req_valid=4'b0100, addr=5, data=24'hABCDEF -> req_ready=4'b0100 in the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=24'hABCDEF, wr_src=2.
- Round robin with wrap: all four valid for 6 cycles -> grants 0,1,2,3,0,1, with wr_en=1 on every cycle starting the cycle after the first grant.
- Stall: all valid, raise wr_stall for 3 cycles after grant to requester 1 -> one write (src 1) appears, then wr_en=0 for 3 cycles; after release the next grant goes to requester 2.
- Withdrawal and mid-op reset: requester 3 valid then dropped before grant -> no write from 3. Pulse rst on the cycle after a grant -> wr_en stays 0 and rr_ptr returns to 0.
- REGARB_LOCK_EN: requester 1 transfers with lock=1 for 3 beats while 0, 2 and 3 are valid -> grants 1,1,1. Requester 1 then transfers with lock=0 -> the following grant goes to requester 2.
